// File: rtl/root_5_en_multi_cycle.sv
// rtl/root_5_en_multi_cycle.sv - integer fifth root, bit-serial restoring search
// One shared multiplier builds each candidate^5 over four cycles; one root in flight.
module root_5_en_multi_cycle #(
  parameter int w = 8,
  localparam int rw = (w + 4) / 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          arg_vld,
  input  logic [w-1:0]  n,
  output logic          busy,
  output logic          res_vld,
  output logic [rw-1:0] res
);

  localparam int mw = 5 * rw;
  localparam int bw = (rw > 1) ? $clog2(rw) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    CMP,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [w-1:0]   x;
  logic [rw-1:0]  root;
  logic [bw-1:0]  bit_idx;
  logic [mw-1:0]  mul;
  logic [1:0]     cnt;

  logic [rw-1:0]  cand;
  logic           fit;
  logic           last_bit;
  logic           accepting;

  // root is stable from LOAD through CMP, so the candidate never needs its own register
  assign cand      = root | (rw'(1) << bit_idx);
  assign fit       = mul <= mw'(x);
  assign last_bit  = (bit_idx == '0);
  assign accepting = (state == IDLE) || (state == DONE);

  assign busy    = (state == LOAD) || (state == MUL) || (state == CMP);
  assign res_vld = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = arg_vld ? LOAD : IDLE;
      LOAD:       state_nxt = MUL;
      MUL:        state_nxt = (cnt == 2'd3) ? CMP : MUL;
      CMP:        state_nxt = last_bit ? DONE : LOAD;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      root    <= '0;
      bit_idx <= '0;
      mul     <= '0;
      cnt     <= '0;
      res     <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (accepting && arg_vld) begin
        x       <= n;
        root    <= '0;
        bit_idx <= bw'(rw - 1);
      end
      case (state)
        LOAD: begin
          mul <= mw'(cand);
          cnt <= 2'd0;
        end
        MUL: begin
          // four passes turn cand into cand^5; cand < 2^rw keeps it inside mw bits
          mul <= mul * mw'(cand);
          cnt <= cnt + 2'd1;
        end
        CMP: begin
          if (fit) root <= cand;
          if (last_bit) res <= fit ? cand : root;
          else          bit_idx <= bit_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
